iterative_divider: RTL and testbench
====================================

// Module: iterative_divider
// PURPOSE
//  Multi-cycle restoring divider: the inverse of the ALU's add/multiply path.
//  Computes quotient and remainder, one bit per clock, using a single (W+1)-bit
//  trial subtractor (ripple of full-adder cells, B inverted, carry-in = 1).
//  Sits beside the ALU and serves DIV/DIVU/REM/REMU.
//  Handshake: START in; BUSY and a one-cycle DONE out.
// PARAMETERS
//  W  32  operand, quotient and remainder width in bits
// PORTS
//  CLK          in   1  system clock; all state updates on the rising edge
//  RST          in   1  asynchronous, active-low reset
//  START        in   1  begin an operation; sampled only in IDLE
//  SIGNED_OP    in   1  1 = two's-complement operands, 0 = unsigned
//  DIVIDEND     in   W  numerator; captured on the accepted START edge
//  DIVISOR      in   W  denominator; captured on the accepted START edge
//  QUOTIENT     out  W  result; held until the next accepted START
//  REMAINDER    out  W  result; held until the next accepted START
//  BUSY         out  1  high in RUN and FIX
//  DONE         out  1  one-cycle pulse in the DONE state
//  DIV_BY_ZERO  out  1  flag for the last op; valid with DONE, held with the results
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE; QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO = 0.
//  States: IDLE -> RUN -> FIX -> DONE -> IDLE.
//  IDLE, START=1 at edge t0:
//   - Latch operand magnitudes (|x| when SIGNED_OP and MSB=1, else raw).
//   - Latch the sign flags: qneg = sA ^ sB, rneg = sA.
//   - Clear R; load iteration counter = W.
//   - If DIVISOR == 0, go directly to DONE instead.
//  RUN (W cycles, edges t1..tW):
//   - Shift {R,Q} left by 1; trial T = {R,Qmsb} - D, computed in W+1 bits.
//   - If T >= 0: R = T and Q[0] = 1. Else R keeps the shifted value and Q[0] = 0.
//   - Decrement counter; go to FIX when counter reaches 0.
//  FIX (edge tW+1):
//   - QUOTIENT = qneg ? -Q : Q.
//   - REMAINDER = rneg ? -R : R (remainder takes the dividend's sign).
//  DONE (entered at edge tW+2): DONE=1 for exactly one cycle, BUSY=0, then IDLE.
//  Latency: DONE high 34 cycles after the START edge for W=32 (W+2 in general).
//  Divide-by-zero: DONE on the edge after START (latency 1).
//   - QUOTIENT = all ones, REMAINDER = DIVIDEND (raw), DIV_BY_ZERO = 1.
//  Signed overflow MIN/-1: no special case. |MIN| = 2^(W-1) fits unsigned;
//   result is QUOTIENT = MIN, REMAINDER = 0, DIV_BY_ZERO = 0.
//  START while BUSY or in DONE: ignored; no effect on the operation in flight.
//  START held high: a new operation begins on the first edge in IDLE after DONE.
//  RST low mid-operation: immediate return to IDLE with outputs cleared.
//   No partial result is retained.
//  Results change only at FIX, or at DONE for divide-by-zero.
//   QUOTIENT and REMAINDER are not cleared by a new START.
// STRUCTURE
//  Shared definition header holds:
//   - `DATA_WIDTH (32).
//   - Divider state encodings: IDLE=2'b00, RUN=2'b01, FIX=2'b10, DONE=2'b11.
//   - Counter width: clog2(W)+1.
//  One sub-module, trial_subtractor:
//   - (W+1)-bit ripple chain of FULL_ADDER cells, computing A + ~B + 1.
//   - Outputs the difference and the borrow-free flag (carry-out).
//  The same sub-module performs the FIX-state negations as 0 - x.
//  Top level holds the FSM, counter, R/Q/D registers and the output registers.
// TESTING
//  1. Unsigned 100/7, START 1 cycle:
//     QUOTIENT=14, REMAINDER=2, DONE pulses 34 cycles later, BUSY high 33 cycles.
//  2. Signed -7/2 (0xFFFFFFF9 / 2):
//     QUOTIENT=0xFFFFFFFD, REMAINDER=0xFFFFFFFF. Unsigned 0xFFFFFFF9/2 -> 0x7FFFFFFC, 1.
//  3. 5/0, either signedness:
//     next-edge DONE, QUOTIENT=0xFFFFFFFF, REMAINDER=5, DIV_BY_ZERO=1.
//     Then 9/3 -> 3, 0, flag cleared.
//  4. Signed 0x80000000 / 0xFFFFFFFF:
//     QUOTIENT=0x80000000, REMAINDER=0, DIV_BY_ZERO=0.
//  5. RST low 10 cycles into 1000/10:
//     BUSY, DONE and outputs go to 0 asynchronously.
//     A new START 50/5 yields 10, 0 after 34 cycles.
//  6. START re-pulsed during RUN with new operands:
//     first result unaffected, exactly one DONE pulse.

Source files
------------

// File: rtl/iterative_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iterative_divider_pkg
// Description : Shared width, state encodings and counter sizing for the
//               iterative restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package iterative_divider_pkg;

    localparam int unsigned c_data_width = 32;

    typedef logic [1:0] div_state_t;

    localparam div_state_t c_st_idle = 2'b00;
    localparam div_state_t c_st_run  = 2'b01;
    localparam div_state_t c_st_fix  = 2'b10;
    localparam div_state_t c_st_done = 2'b11;

    // Wide enough to hold the value W itself, not just W-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iterative_divider_trial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : iterative_divider_trial_subtractor
// Description : Ripple chain of full-adder cells computing A + ~B + 1.
//               o_no_borrow is the carry-out, set when A >= B (unsigned).
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_divider_trial_subtractor #(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_no_borrow
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_cin;
        logic w_cout;
        logic w_nb;

        if (i == 0) begin : g_lsb
            assign w_cin = 1'b1;
        end else begin : g_chain
            assign w_cin = g_fa[i-1].w_cout;
        end

        assign w_nb      = ~i_b[i];
        assign o_diff[i] = i_a[i] ^ w_nb ^ w_cin;
        assign w_cout    = (i_a[i] & w_nb) | (i_a[i] & w_cin) | (w_nb & w_cin);
    end

    assign o_no_borrow = g_fa[WIDTH-1].w_cout;

endmodule
`default_nettype wire

// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
// Module      : iterative_divider
// Description : Multi-cycle restoring divider, one quotient bit per clock,
//               signed/unsigned, with START / BUSY / DONE handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int unsigned W = c_data_width
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_signed_op,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_div_by_zero
);

    localparam int unsigned c_cnt_w = cnt_width(W);

    div_state_t         r_state;
    div_state_t         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_quo;
    logic [W-1:0]       r_div;
    logic [W-1:0]       r_quotient;
    logic [W-1:0]       r_remainder;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_dbz;

    logic               w_busy;
    logic               w_done;
    logic               w_divisor_zero;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [W-1:0]       w_mag_a;
    logic [W-1:0]       w_mag_b;
    logic [W:0]         w_trial_a;
    logic [W:0]         w_trial_b;
    logic [W:0]         w_trial_diff;
    logic               w_trial_ok;
    logic [W-1:0]       w_neg_q;
    logic [W-1:0]       w_neg_r;
    logic               w_neg_q_co;
    logic               w_neg_r_co;
    logic               w_unused;

    assign w_divisor_zero = (i_divisor == '0);
    assign w_sign_a       = i_signed_op & i_dividend[W-1];
    assign w_sign_b       = i_signed_op & i_divisor[W-1];
    assign w_mag_a        = w_sign_a ? (~i_dividend + W'(1)) : i_dividend;
    assign w_mag_b        = w_sign_b ? (~i_divisor + W'(1)) : i_divisor;

    // Shifted partial remainder {R, Q msb}; its top bit is always clear when
    // the trial fails because the shifted value is then below the divisor.
    assign w_trial_a = {r_rem, r_quo[W-1]};
    assign w_trial_b = {1'b0, r_div};

    iterative_divider_trial_subtractor #(.WIDTH(W + 1)) u_trial (
        .i_a         (w_trial_a),
        .i_b         (w_trial_b),
        .o_diff      (w_trial_diff),
        .o_no_borrow (w_trial_ok)
    );

    iterative_divider_trial_subtractor #(.WIDTH(W)) u_neg_q (
        .i_a         ('0),
        .i_b         (r_quo),
        .o_diff      (w_neg_q),
        .o_no_borrow (w_neg_q_co)
    );

    iterative_divider_trial_subtractor #(.WIDTH(W)) u_neg_r (
        .i_a         ('0),
        .i_b         (r_rem),
        .o_diff      (w_neg_r),
        .o_no_borrow (w_neg_r_co)
    );

    assign w_unused = w_trial_diff[W] ^ w_neg_q_co ^ w_neg_r_co;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (i_start) begin
                    w_next_state = w_divisor_zero ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (r_cnt == c_cnt_w'(1)) begin
                    w_next_state = c_st_fix;
                end
            end
            c_st_fix: w_next_state = c_st_done;
            default:  w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_st_run, c_st_fix: w_busy = 1'b1;
            c_st_done:          w_done = 1'b1;
            default:            ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_start) begin
                        r_rem  <= '0;
                        r_quo  <= w_mag_a;
                        r_div  <= w_mag_b;
                        r_cnt  <= c_cnt_w'(W);
                        r_qneg <= w_sign_a ^ w_sign_b;
                        r_rneg <= w_sign_a;
                        // Divide-by-zero skips the iterations entirely.
                        if (w_divisor_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= i_dividend;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                c_st_run: begin
                    r_rem <= w_trial_ok ? w_trial_diff[W-1:0] : w_trial_a[W-1:0];
                    r_quo <= {r_quo[W-2:0], w_trial_ok};
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
                c_st_fix: begin
                    r_quotient  <= r_qneg ? w_neg_q : r_quo;
                    r_remainder <= r_rneg ? w_neg_r : r_rem;
                    r_dbz       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_busy        = w_busy;
    assign o_done        = w_done;
    assign o_div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_iterative_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_divider
// Description : Self-checking bench for iterative_divider: directed vector
//               table, multi-cycle corner sequences and random operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_divider;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start     = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend  = '0;
    logic [W-1:0] divisor   = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dbz;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           z;
    } vec_t;

    vec_t tbl[13];

    iterative_divider #(.W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_signed_op   (signed_op),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: 64-bit arithmetic sidesteps the MIN / -1 overflow.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
            return;
        end
        z = 1'b0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Called just after a rising edge with the DUT idle; returns the same way.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         output int lat, output int busy_cnt, output bit pulse_ok);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        signed_op = s;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        pulse_ok = !done && !busy;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat, bc;
        bit ok;
        do_op(v.a, v.b, v.s, lat, bc, ok);
        check({name, ".quotient"},  quotient,  v.q);
        check({name, ".remainder"}, remainder, v.r);
        check({name, ".div_by_zero"}, W'(dbz), W'(v.z));
        check({name, ".latency"},   W'(lat), v.z ? 1 : 34);
        check({name, ".busy_cycles"}, W'(bc), v.z ? 0 : 33);
        check({name, ".done_pulse"}, W'(ok), 1);
    endtask

    initial begin
        int   done_cnt, first_done, second_done;
        vec_t v;

        tbl[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0};
        tbl[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        tbl[2]  = '{32'hFFFFFFF9, 32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        1'b0};
        tbl[3]  = '{32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, 32'd5,        1'b1};
        tbl[4]  = '{32'd9,        32'd3,        1'b0, 32'd3,        32'd0,        1'b0};
        tbl[5]  = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1};
        tbl[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0};
        tbl[7]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0};
        tbl[8]  = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        tbl[9]  = '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0};
        tbl[10] = '{32'd7,        32'd100,      1'b0, 32'd0,        32'd7,        1'b0};
        tbl[11] = '{32'd0,        32'd5,        1'b1, 32'd0,        32'd0,        1'b0};
        tbl[12] = '{32'hFFFFFFF9, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset.quotient",    quotient,  '0);
        check("reset.remainder",   remainder, '0);
        check("reset.busy",        W'(busy),  '0);
        check("reset.done",        W'(done),  '0);
        check("reset.div_by_zero", W'(dbz),   '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Asynchronous reset mid-operation; previous op left the flag and all-ones set.
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst.quotient",    quotient,  '0);
        check("midrst.remainder",   remainder, '0);
        check("midrst.busy",        W'(busy),  '0);
        check("midrst.done",        W'(done),  '0);
        check("midrst.div_by_zero", W'(dbz),   '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec("after_rst", '{32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0});

        // START re-pulsed during RUN with different operands must be ignored.
        start = 1'b1; dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; dividend = 32'd200; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 45; c++) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        check("restart.done_count", W'(done_cnt), 1);
        check("restart.quotient",   quotient,  32'd14);
        check("restart.remainder",  remainder, 32'd2);

        // START held high: next op begins on the first idle edge after DONE.
        start = 1'b1; dividend = 32'd9; divisor = 32'd3; signed_op = 1'b0;
        first_done  = -1;
        second_done = -1;
        for (int c = 0; c < 100 && second_done < 0; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (first_done < 0) first_done = c;
                else begin
                    second_done = c;
                    start = 1'b0;
                end
            end
        end
        check("held.first_latency", W'(first_done + 1), 34);
        check("held.gap",           W'(second_done - first_done), 35);
        check("held.quotient",      quotient, 32'd3);
        @(posedge clk); #1;

        // Random operands against the arithmetic reference.
        for (int k = 0; k < 40; k++) begin
            v.a = $urandom;
            case ($urandom_range(0, 7))
                0:       v.b = '0;
                1:       v.b = $urandom_range(1, 15);
                2:       v.b = '1;
                3:       v.b = v.a >> $urandom_range(0, 31);
                default: v.b = $urandom;
            endcase
            v.s = 1'($urandom_range(0, 1));
            model(v.a, v.b, v.s, v.q, v.r, v.z);
            run_vec($sformatf("rand%0d", k), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
